// File: rtl/ap_job_sequencer_if.sv
// Streaming and AP_s bus bundle for the job sequencer.
// master = sequencer side, slave = operand source / result sink / AP_s side.
interface ap_job_sequencer_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_W    = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic                 ap_rst;
  logic [ADDR_W-1:0]    ap_addr;
  logic [WORD_SIZE-1:0] ap_data_in;
  logic                 ap_mode;
  logic [2:0]           ap_cmd;
  logic [1:0]           ap_sel_col;
  logic                 ap_sel_internal_col;
  logic                 ap_write_en;
  logic                 ap_read_en;
  logic [WORD_SIZE-1:0] ap_data_out;
  logic                 ap_state_irq;

  modport master (
    input  in_valid, in_data, out_ready,
    input  ap_data_out, ap_state_irq,
    output in_ready, out_valid, out_data,
    output ap_rst, ap_addr, ap_data_in, ap_mode, ap_cmd,
    output ap_sel_col, ap_sel_internal_col,
    output ap_write_en, ap_read_en
  );

  modport slave (
    output in_valid, in_data, out_ready,
    output ap_data_out, ap_state_irq,
    input  in_ready, out_valid, out_data,
    input  ap_rst, ap_addr, ap_data_in, ap_mode, ap_cmd,
    input  ap_sel_col, ap_sel_internal_col,
    input  ap_write_en, ap_read_en
  );
endinterface

// File: rtl/ap_job_sequencer.sv
// Host-side job sequencer for the AP_s associative processor:
// load A/B, clear, run one pass, read C back onto a stream.
module ap_job_sequencer #(
  parameter int WORD_SIZE   = 8,
  parameter int CELL_QUANT  = 512,
  parameter int READ_LAT    = 2,
  parameter int AP_RST_CYC  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic timeout_err,
  ap_job_sequencer_if.master bus
);

  localparam int ADDR_W =
    (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(CELL_QUANT - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLR      = 4'd1;
  localparam logic [3:0] S_LOAD_A   = 4'd2;
  localparam logic [3:0] S_LOAD_B   = 4'd3;
  localparam logic [3:0] S_RUN      = 4'd4;
  localparam logic [3:0] S_RD_ISSUE = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_RD_OUT   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]           state;
  logic [ADDR_W-1:0]    k;
  logic                 ph;
  logic [15:0]          cnt;
  logic                 ap_rst_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_SIZE-1:0] din_q;
  logic                 mode_q;
  logic [1:0]           sel_q;
  logic                 we_q;
  logic                 re_q;
  logic                 ov_q;
  logic [WORD_SIZE-1:0] od_q;
  logic                 done_q;
  logic                 terr_q;
  logic                 loading;

  assign loading = (state == S_LOAD_A) || (state == S_LOAD_B);

  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;

  assign bus.in_ready            = loading && !ph;
  assign bus.out_valid           = ov_q;
  assign bus.out_data            = od_q;
  assign bus.ap_rst              = ap_rst_q;
  assign bus.ap_addr             = addr_q;
  assign bus.ap_data_in          = din_q;
  assign bus.ap_mode             = mode_q;
  assign bus.ap_cmd              = 3'b000;
  assign bus.ap_sel_col          = sel_q;
  assign bus.ap_sel_internal_col = 1'b0;
  assign bus.ap_write_en         = we_q;
  assign bus.ap_read_en          = re_q;

  // Job FSM; AP bus outputs are registered so they hold between slots.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      k        <= '0;
      ph       <= 1'b0;
      cnt      <= '0;
      ap_rst_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      mode_q   <= 1'b0;
      sel_q    <= 2'd0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            terr_q   <= 1'b0;
            ap_rst_q <= 1'b1;
            cnt      <= '0;
            k        <= '0;
            ph       <= 1'b0;
            state    <= S_CLR;
          end
        end
        S_CLR: begin
          if (cnt == 16'(AP_RST_CYC - 1)) begin
            ap_rst_q <= 1'b0;
            cnt      <= '0;
            state    <= S_LOAD_A;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (!ph) begin
            if (bus.in_valid) begin
              addr_q <= k;
              din_q  <= bus.in_data;
              sel_q  <= (state == S_LOAD_B) ? 2'd1 : 2'd0;
              we_q   <= 1'b1;
              ph     <= 1'b1;
            end
          end else begin
            // AP_s latches wea a cycle late, so addr_q stays put here
            we_q <= 1'b0;
            ph   <= 1'b0;
            if (k == LAST) begin
              k <= '0;
              if (state == S_LOAD_A) begin
                state <= S_LOAD_B;
              end else begin
                mode_q <= 1'b1;
                cnt    <= '0;
                state  <= S_RUN;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.ap_state_irq) begin
            mode_q <= 1'b0;
            sel_q  <= 2'd2;
            addr_q <= k;
            re_q   <= 1'b1;
            state  <= S_RD_ISSUE;
          end else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
            mode_q <= 1'b0;
            terr_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RD_ISSUE: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (cnt == 16'(READ_LAT - 1)) begin
            od_q  <= bus.ap_data_out;
            ov_q  <= 1'b1;
            re_q  <= 1'b0;
            state <= S_RD_OUT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RD_OUT: begin
          if (bus.out_ready) begin
            ov_q <= 1'b0;
            if (k == LAST) begin
              k     <= '0;
              state <= S_DONE;
            end else begin
              k      <= k + 1'b1;
              addr_q <= k + 1'b1;
              re_q   <= 1'b1;
              state  <= S_RD_ISSUE;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_job_sequencer.sv
// Directed bench for ap_job_sequencer with a small AP_s model
// computing C = A | B.
module tb_ap_job_sequencer;

  localparam int WS = 8;
  localparam int CQ = 4;
  localparam int AW = 2;

  logic CLK100MHZ = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic timeout_err;

  always #5 CLK100MHZ = ~CLK100MHZ;

  ap_job_sequencer_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

  ap_job_sequencer #(
    .WORD_SIZE(WS), .CELL_QUANT(CQ), .READ_LAT(2),
    .AP_RST_CYC(2), .TIMEOUT_CYC(64)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .bus        (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // AP_s model
  logic [WS-1:0] col_a [CQ];
  logic [WS-1:0] col_b [CQ];
  logic [WS-1:0] p1 = '0;
  logic [WS-1:0] p2 = '0;
  logic          irq = 1'b0;
  logic          irq_en = 1'b1;
  int            run_cnt = 0;

  assign bus.ap_data_out  = p2;
  assign bus.ap_state_irq = irq;

  always @(posedge CLK100MHZ) begin
    if (bus.ap_rst) begin
      irq     <= 1'b0;
      run_cnt <= 0;
      for (int i = 0; i < CQ; i++) begin
        col_a[i] <= '0;
        col_b[i] <= '0;
      end
    end else begin
      if (bus.ap_write_en && bus.ap_sel_col == 2'd0)
        col_a[bus.ap_addr] <= bus.ap_data_in;
      if (bus.ap_write_en && bus.ap_sel_col == 2'd1)
        col_b[bus.ap_addr] <= bus.ap_data_in;
      if (bus.ap_mode && irq_en) begin
        run_cnt <= run_cnt + 1;
        if (run_cnt == 3) irq <= 1'b1;
      end
      if (bus.ap_read_en && bus.ap_sel_col == 2'd2)
        p1 <= col_a[bus.ap_addr] | col_b[bus.ap_addr];
      p2 <= p1;
    end
  end

  // Monitor
  logic [WS-1:0] got_q[$];
  int   done_cnt, rst_cyc, mode_cyc;
  bit   saw_valid;
  bit   prev_we, prev_stall, prev_hs;
  logic [AW-1:0] prev_addr;
  logic [WS-1:0] prev_data;
  bit   stress_on = 0;

  initial begin
    done_cnt = 0; rst_cyc = 0; mode_cyc = 0; saw_valid = 0;
    prev_we = 0; prev_stall = 0; prev_hs = 0;
    prev_addr = '0; prev_data = '0;
  end

  always @(negedge CLK100MHZ) begin
    if (rst) begin
      prev_we = 0; prev_stall = 0; prev_hs = 0;
    end else begin
      if (prev_we) begin
        chk("wr_addr_hold", 32'(bus.ap_addr), 32'(prev_addr));
        chk("wr_en_drop", 32'(bus.ap_write_en), 32'd0);
      end
      if (bus.ap_mode)
        chk("mode_no_rw",
            32'({bus.ap_write_en, bus.ap_read_en}), 32'd0);
      if (prev_stall) begin
        chk("out_stable", 32'(bus.out_data), 32'(prev_data));
        chk("out_hold", 32'(bus.out_valid), 32'd1);
      end
      if (prev_hs)
        chk("out_drop", 32'(bus.out_valid), 32'd0);
      if (bus.out_valid) saw_valid = 1;
      if (bus.out_valid && bus.out_ready)
        got_q.push_back(bus.out_data);
      if (done) done_cnt++;
      if (bus.ap_rst) rst_cyc++;
      if (bus.ap_mode) mode_cyc++;
      prev_we    = bus.ap_write_en;
      prev_addr  = bus.ap_addr;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_hs    = bus.out_valid && bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // Result sink
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLK100MHZ);
      #1;
      bus.out_ready = stress_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic feed(input logic [WS-1:0] w [CQ],
                      input int n, input bit gaps,
                      input bit poke);
    for (int i = 0; i < n; i++) begin
      int t;
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge CLK100MHZ);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      if (poke && i == 1) start = 1'b1;
      t = 0;
      @(negedge CLK100MHZ);
      while (!bus.in_ready && t < 50) begin
        @(negedge CLK100MHZ);
        t++;
      end
      if (t >= 50) chk("in_hs_timeout", 32'(t), 32'd0);
      @(posedge CLK100MHZ);
      #1;
      bus.in_valid = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic run_job(input logic [WS-1:0] a [CQ],
                         input logic [WS-1:0] b [CQ],
                         input logic [WS-1:0] e [CQ],
                         input bit stress, input bit to,
                         input bit poke);
    int t;
    got_q.delete();
    done_cnt = 0; rst_cyc = 0; mode_cyc = 0; saw_valid = 0;
    stress_on = stress;
    irq_en = !to;
    @(posedge CLK100MHZ);
    #1 start = 1'b1;
    @(posedge CLK100MHZ);
    #1 start = 1'b0;
    chk("busy_start", 32'(busy), 32'd1);
    chk("terr_clear", 32'(timeout_err), 32'd0);
    feed(a, CQ, stress, 1'b0);
    feed(b, CQ, stress, poke);
    t = 0;
    while (done_cnt == 0 && t < 600) begin
      @(posedge CLK100MHZ);
      #1;
      t++;
    end
    repeat (3) @(posedge CLK100MHZ);
    #1;
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("ap_rst_cycles", 32'(rst_cyc), 32'd2);
    chk("busy_end", 32'(busy), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(to));
    if (to) begin
      chk("run_cycles", 32'(mode_cyc), 32'd64);
      chk("no_out_valid", 32'(saw_valid), 32'd0);
    end
    chk("out_count", 32'(got_q.size()), to ? 32'd0 : 32'(CQ));
    for (int i = 0; i < got_q.size() && i < CQ; i++)
      chk($sformatf("out_word%0d", i), 32'(got_q[i]), 32'(e[i]));
    stress_on = 0;
  endtask

  logic [WS-1:0] a1 [CQ] = '{8'h0F, 8'hF0, 8'hAA, 8'h00};
  logic [WS-1:0] b1 [CQ] = '{8'hF0, 8'h0F, 8'h55, 8'h00};
  logic [WS-1:0] e1 [CQ] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
  logic [WS-1:0] a2 [CQ] = '{8'h12, 8'h34, 8'h80, 8'h01};
  logic [WS-1:0] b2 [CQ] = '{8'h21, 8'h43, 8'h08, 8'hFE};
  logic [WS-1:0] e2 [CQ] = '{8'h33, 8'h77, 8'h88, 8'hFF};
  logic [WS-1:0] a3 [CQ] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [WS-1:0] b3 [CQ] = '{8'h10, 8'h20, 8'h40, 8'h80};
  logic [WS-1:0] e3 [CQ] = '{8'h11, 8'h22, 8'h44, 8'h88};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge CLK100MHZ);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out", 32'({bus.out_valid, bus.out_data}), 32'd0);
    chk("rst_ap_ctl",
        32'({bus.ap_rst, bus.ap_mode, bus.ap_write_en,
             bus.ap_read_en, bus.ap_sel_col, bus.ap_addr}), 32'd0);
    rst = 1'b0;

    run_job(a1, b1, e1, 1'b0, 1'b0, 1'b0);
    run_job(a2, b2, e2, 1'b1, 1'b0, 1'b0);
    run_job(a3, b3, e3, 1'b0, 1'b1, 1'b0);
    run_job(a1, b1, e1, 1'b0, 1'b0, 1'b0);

    // Reset during LOAD_B word 2
    @(posedge CLK100MHZ);
    #1 start = 1'b1;
    @(posedge CLK100MHZ);
    #1 start = 1'b0;
    feed(a2, CQ, 1'b0, 1'b0);
    feed(b2, 2, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = b2[2];
    @(posedge CLK100MHZ);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_ap",
        32'({bus.ap_write_en, bus.ap_sel_col, bus.ap_addr,
             bus.ap_data_in}), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge CLK100MHZ);
    #1 rst = 1'b0;
    run_job(a2, b2, e2, 1'b0, 1'b0, 1'b0);

    // Start held during load of the second job is ignored
    run_job(a3, b3, e3, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
